spi_rx: RTL

SPI_RX -- requirements
Module: spi_rx

---
 rtl/spi_rx.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_rx.sv
// SPI receiver: CLK idles high, data LSB first, bytes queued in a show-ahead FIFO.
// Define SPI_RX_FILTER_EN to add a two-sample glitch filter on the synchronized SPI clock.
module spi_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_SPI_Stb,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_Dio,
  input  logic       i_Rd,
  output logic       o_Empty,
  output logic [7:0] o_Data,
  output logic       o_Is_Cmd,
  output logic       o_Frame_End,
  output logic       o_Frame_Err,
  output logic       o_Overflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
`ifdef SPI_RX_FILTER_EN
  localparam logic [1:0]  SYNC_LAT = 2'd3;
`else
  localparam logic [1:0]  SYNC_LAT = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

  logic [1:0] stb_sync_q, clk_sync_q, dio_sync_q;
  logic       stb_prev_q, clk_prev_q;
  logic       stb_use, clk_use, dio_use;
  logic       clk_rise, stb_fall, stb_rise;

  // Input synchronizers; reset to the idle-high level of the bus
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stb_sync_q <= 2'b11;
      clk_sync_q <= 2'b11;
      dio_sync_q <= 2'b11;
      stb_prev_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[0], i_SPI_Stb};
      clk_sync_q <= {clk_sync_q[0], i_SPI_Clk};
      dio_sync_q <= {dio_sync_q[0], i_SPI_Dio};
      stb_prev_q <= stb_use;
      clk_prev_q <= clk_use;
    end
  end

`ifdef SPI_RX_FILTER_EN
  logic stb_dly_q, clk_dly_q, dio_dly_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stb_dly_q <= 1'b1;
      clk_dly_q <= 1'b1;
      dio_dly_q <= 1'b1;
    end else begin
      stb_dly_q <= stb_sync_q[1];
      clk_dly_q <= clk_sync_q[1];
      dio_dly_q <= dio_sync_q[1];
    end
  end

  // A new CLK level is taken only once two consecutive samples agree; otherwise hold
  assign clk_use = (clk_sync_q[1] == clk_dly_q) ? clk_sync_q[1] : clk_prev_q;
  assign stb_use = stb_dly_q;
  assign dio_use = dio_dly_q;
`else
  assign clk_use = clk_sync_q[1];
  assign stb_use = stb_sync_q[1];
  assign dio_use = dio_sync_q[1];
`endif

  assign clk_rise = clk_use & ~clk_prev_q;
  assign stb_fall = ~stb_use & stb_prev_q;
  assign stb_rise = stb_use & ~stb_prev_q;

  // Arming: STB must be seen high through a filled synchronizer before a frame can open
  logic [1:0] warm_q, warm_d;
  logic       arm_q, arm_d;

  always_comb begin
    warm_d = warm_q;
    if (warm_q != SYNC_LAT) begin
      warm_d = warm_q + 2'd1;
    end
    arm_d = arm_q | ((warm_q == SYNC_LAT) & stb_use);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      warm_q <= 2'd0;
      arm_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      arm_q  <= arm_d;
    end
  end

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d;
  logic [7:0] shift_q, shift_d;
  logic       push_q, push_d;
  logic [8:0] push_data_q, push_data_d;
  logic       frame_end, frame_err;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_end   = 1'b0;
    frame_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm_q && stb_fall) begin
          state_d   = RECV;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
          first_d   = 1'b1;
        end
      end
      RECV: begin
        // A bit arriving with the closing STB edge is still counted
        if (clk_rise) begin
          shift_d = {dio_use, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            push_d      = 1'b1;
            push_data_d = {first_q, dio_use, shift_q[7:1]};
            first_d     = 1'b0;
            bit_cnt_d   = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        if (stb_rise) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        frame_end = 1'b1;
        frame_err = (bit_cnt_q != 3'd0);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      first_q   <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      push_q    <= push_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    shift_q     <= shift_d;
    push_data_q <= push_data_d;
  end

  assign o_Frame_End = frame_end;
  assign o_Frame_Err = frame_err;

  // Receive FIFO: a full FIFO still accepts a push when the same cycle pops
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = i_Rd & ~empty;
  assign do_push = push_q & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_q && !do_push) begin
      ovf_d = 1'b1;
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  assign o_Empty    = empty;
  assign o_Data     = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign o_Is_Cmd   = empty ? 1'b0  : mem_q[rd_ptr_q][8];
  assign o_Overflow = ovf_q;

endmodule
